// File: rtl/fetch_queue_if.sv
// Fetch-to-decode queue bundle: enqueue side, dequeue side, redirect flush and occupancy.
// master = the pipeline driving fetch/decode; slave = the queue itself.
interface fetch_queue_if #(
  parameter int ADDR_LEN = 32,
  parameter int INSN_LEN = 32,
  parameter int PTR_W    = 2
);
  // Handshake: a transfer happens on a rising clk edge when valid and ready are
  // both high and flush is low; valid must be held until ready, and ready never
  // depends combinationally on the other side's valid or ready.
  logic                flush;
  logic                enq_valid;
  logic                enq_ready;
  logic [ADDR_LEN-1:0] enq_pc;
  logic [INSN_LEN-1:0] enq_inst;
  logic                deq_valid;
  logic                deq_ready;
  logic [ADDR_LEN-1:0] deq_pc;
  logic [INSN_LEN-1:0] deq_inst;
  logic [PTR_W:0]      count;

  modport master (
    output flush, enq_valid, enq_pc, enq_inst, deq_ready,
    input  enq_ready, deq_valid, deq_pc, deq_inst, count
  );

  modport slave (
    input  flush, enq_valid, enq_pc, enq_inst, deq_ready,
    output enq_ready, deq_valid, deq_pc, deq_inst, count
  );
endinterface

// File: rtl/fetch_queue.sv
// In-order {pc, inst} buffer between fetch and decode, cleared by a redirect flush.
// All outputs come from registered state only; an entry becomes visible the cycle after its push.
module fetch_queue #(
  parameter int                  DEPTH    = 4,
  parameter int                  PTR_W    = 2,
  parameter int                  ADDR_LEN = 32,
  parameter int                  INSN_LEN = 32,
  parameter logic [INSN_LEN-1:0] NOP_INSN = 32'h00000013
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.slave  q
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [ADDR_LEN-1:0] pc_mem_q   [DEPTH];
  logic [INSN_LEN-1:0] inst_mem_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic full, empty, push, pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // enq_ready ignores deq_ready on purpose, so a full queue refuses even during a pop.
  assign q.enq_ready = !full;
  assign q.deq_valid = !empty;
  assign q.deq_pc    = empty ? '0       : pc_mem_q[head_q];
  assign q.deq_inst  = empty ? NOP_INSN : inst_mem_q[head_q];
  assign q.count     = count_q;

  assign push = q.enq_valid & !full  & !q.flush;
  assign pop  = q.deq_ready & !empty & !q.flush;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (q.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Pointers are PTR_W bits wide and DEPTH is a power of two, so +1 wraps naturally.
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; the empty check masks stale contents on the outputs.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[tail_q]   <= q.enq_pc;
      inst_mem_q[tail_q] <= q.enq_inst;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, latency, full refusal, wrap-around,
// flush priority and asynchronous reset mid-stream.
module tb_fetch_queue;

  localparam logic [31:0] NOP = 32'h00000013;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;

  fetch_queue_if #(.ADDR_LEN(32), .INSN_LEN(32), .PTR_W(2)) bus ();

  fetch_queue #(
    .DEPTH(4), .PTR_W(2), .ADDR_LEN(32), .INSN_LEN(32), .NOP_INSN(NOP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .q     (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush     = 1'b0;
    bus.enq_valid = 1'b0;
    bus.enq_pc    = '0;
    bus.enq_inst  = '0;
    bus.deq_ready = 1'b0;
  endtask

  task automatic push_one(input logic [31:0] pc, input logic [31:0] inst);
    bus.enq_valid = 1'b1;
    bus.enq_pc    = pc;
    bus.enq_inst  = inst;
    step();
    bus.enq_valid = 1'b0;
    exp_q.push_back(pc);
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_count"},     32'(bus.count), 32'd0);
    check({tag, "_deq_valid"}, 32'(bus.deq_valid), 32'd0);
    check({tag, "_enq_ready"}, 32'(bus.enq_ready), 32'd1);
    check({tag, "_deq_pc"},    bus.deq_pc, 32'd0);
    check({tag, "_deq_inst"},  bus.deq_inst, NOP);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    idle_inputs();
    reset = 1'b0;
    #1;
    check_empty("async_reset");
    #11 reset = 1'b1;
    step();
    check_empty("idle");

    // single push, one-cycle latency, stable while held
    bus.deq_ready = 1'b0;
    push_one(32'h100, 32'h00500093);
    check("one_valid", 32'(bus.deq_valid), 32'd1);
    check("one_pc",    bus.deq_pc, 32'h100);
    check("one_inst",  bus.deq_inst, 32'h00500093);
    check("one_count", 32'(bus.count), 32'd1);
    step();
    step();
    check("hold_pc",   bus.deq_pc, 32'h100);
    check("hold_inst", bus.deq_inst, 32'h00500093);
    bus.deq_ready = 1'b1;
    step();
    bus.deq_ready = 1'b0;
    void'(exp_q.pop_front());
    check_empty("drained");

    // fill to full, then hold a fifth request
    for (int i = 0; i < 4; i++) push_one(32'(4 * i), 32'h00100093 + 32'(i));
    check("full_count", 32'(bus.count), 32'd4);
    check("full_ready", 32'(bus.enq_ready), 32'd0);
    bus.enq_valid = 1'b1;
    bus.enq_pc    = 32'h10;
    bus.enq_inst  = 32'h00A00093;
    step();
    step();
    check("full_refused", 32'(bus.count), 32'd4);
    check("full_head_inst", bus.deq_inst, 32'h00100093);

    // pop all four; the held 0x10 goes in once enq_ready rises
    bus.deq_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_pc = exp_q.pop_front();
      check("pop_order", bus.deq_pc, exp_pc);
      if (i == 0) check("refuse_during_pop", 32'(bus.enq_ready), 32'd0);
      if (i == 1) begin
        check("ready_after_pop", 32'(bus.enq_ready), 32'd1);
        exp_q.push_back(32'h10);
      end
      step();
      if (i == 1) bus.enq_valid = 1'b0;
    end
    bus.deq_ready = 1'b0;
    check("late_count", 32'(bus.count), 32'd1);
    check("late_pc",    bus.deq_pc, 32'h10);

    // simultaneous push and pop at count=2, pointers wrap
    push_one(32'h20, 32'h00200093);
    check("pp_start_count", 32'(bus.count), 32'd2);
    bus.deq_ready = 1'b1;
    bus.enq_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.enq_pc   = 32'h24 + 32'(4 * k);
      bus.enq_inst = 32'h00300093 + 32'(k);
      exp_pc = exp_q.pop_front();
      check("pp_order", bus.deq_pc, exp_pc);
      exp_q.push_back(bus.enq_pc);
      step();
      check("pp_count", 32'(bus.count), 32'd2);
    end
    idle_inputs();
    check("pp_head", bus.deq_pc, 32'h34);

    // flush at count=3 beats a simultaneous push and pop
    push_one(32'h3C, 32'h00400093);
    check("pre_flush_count", 32'(bus.count), 32'd3);
    bus.flush     = 1'b1;
    bus.enq_valid = 1'b1;
    bus.enq_pc    = 32'h40;
    bus.enq_inst  = 32'h00600093;
    bus.deq_ready = 1'b1;
    step();
    idle_inputs();
    exp_q.delete();
    check_empty("flush");
    bus.flush = 1'b1;
    step();
    step();
    bus.flush = 1'b0;
    check_empty("flush_twice");
    push_one(32'h50, 32'h00700093);
    check("post_flush_count", 32'(bus.count), 32'd1);
    check("post_flush_pc",    bus.deq_pc, 32'h50);
    bus.deq_ready = 1'b1;
    step();
    bus.deq_ready = 1'b0;
    exp_q.delete();

    // asynchronous reset between edges at count=3
    push_one(32'h60, 32'h00800093);
    push_one(32'h64, 32'h00900093);
    push_one(32'h68, 32'h00A00093);
    check("pre_reset_count", 32'(bus.count), 32'd3);
    #2 reset = 1'b0;
    #1;
    check_empty("mid_reset");
    #2 reset = 1'b1;
    exp_q.delete();
    step();
    check_empty("after_reset");
    push_one(32'h70, 32'h00B00093);
    check("after_reset_pc",    bus.deq_pc, 32'h70);
    check("after_reset_count", 32'(bus.count), 32'd1);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Small in-order instruction buffer between instruction fetch and decode; each entry holds a fetched instruction word and its PC.
- Fetch pushes {pc, inst} pairs. Decode pops them and feeds the instruction word to the immediate generator and the rest of the decoder.
- Decouples fetch from decode back-pressure.
- Discards all contents on a pipeline redirect (branch, jump or exception flush).

Parameters:
- DEPTH, 4, number of entries; must be a power of two, at least 2.
- PTR_W, 2, pointer width, equal to log2(DEPTH).
- NOP_INSN, 32'h00000013, instruction word driven on deq_inst while the queue is empty (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous discard of all entries (redirect).
- enq_valid  in  1  fetch presents an instruction.
- enq_ready  out  1  queue can accept an instruction this cycle.
- enq_pc  in  `ADDR_LEN  PC of the presented instruction.
- enq_inst  in  `INSN_LEN  presented instruction word.
- deq_valid  out  1  head entry valid.
- deq_ready  in  1  decode consumes the head this cycle.
- deq_pc  out  `ADDR_LEN  PC of the head entry.
- deq_inst  out  `INSN_LEN  instruction word of the head entry.
- count  out  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH-entry register array of {pc, inst}, plus head pointer, tail pointer (PTR_W bits, wrap modulo DEPTH) and count (PTR_W+1 bits).
- Reset (reset=0, asynchronous):
  - head, tail and count clear to 0; count=0.
  - deq_valid=0, enq_ready=1, deq_pc=0, deq_inst=NOP_INSN.
  - Array contents need not be cleared.
- Derived signals (all from registered state; no combinational path from any input to any output):
  - full = (count==DEPTH); empty = (count==0).
  - enq_ready = !full. It does not depend on deq_ready, so enqueue into a full queue is refused even when a pop occurs in the same cycle.
  - deq_valid = !empty.
  - deq_pc/deq_inst = array[head] when !empty; otherwise 0 / NOP_INSN.
- Transfer conditions:
  - push = enq_valid & enq_ready & !flush.
  - pop = deq_valid & deq_ready & !flush.
- Push: array[tail] <= {enq_pc, enq_inst}; tail <= tail+1, wrapping from DEPTH-1 to 0.
- Pop: head <= head+1, wrapping.
- Count update:
  - push & !pop: +1.
  - pop & !push: -1.
  - push & pop: unchanged. Only possible when 0<count<DEPTH; both pointers advance.
- Latency: an entry pushed in cycle N is visible at deq_* in cycle N+1. There is no same-cycle fall-through, even when empty.
- Ordering: strict FIFO; PCs leave in the order accepted.
- Flush:
  - On the next edge, head, tail and count go to 0. The flush has priority over push and pop in the same cycle, so both are ignored.
  - The cycle after a flush: deq_valid=0, enq_ready=1.
  - Back-to-back flushes are legal and idempotent.
- deq_ready while empty: no effect. enq_valid while full: no effect; fetch must hold its request until enq_ready.
- Data stability: while deq_valid=1 and deq_ready=0, deq_pc/deq_inst stay stable regardless of pushes (writes never target head while count>0 and count<DEPTH).
- Reset asserted mid-operation: immediately forces the reset state regardless of clk. Contents are lost; no partial state survives.

Test Plan:
- Reset, then idle -> count=0, deq_valid=0, enq_ready=1, deq_pc=0, deq_inst=32'h00000013.
- Push pc=0x100 inst=0x00500093 with deq_ready=0 -> next cycle deq_valid=1, deq_pc=0x100, deq_inst=0x00500093, count=1; this pair stays stable while deq_ready=0.
- Push 4 entries (pc 0x0,0x4,0x8,0xC), then hold enq_valid=1 with a 5th (pc 0x10) -> count=4, enq_ready=0, pc 0x10 not accepted; pop all 4 -> order 0x0,0x4,0x8,0xC; 0x10 accepted once enq_ready=1.
- At count=2, simultaneous push and pop for 6 cycles -> count remains 2, pointers wrap past DEPTH-1, dequeued PCs strictly ascending with no loss or duplication.
- At count=3, assert flush together with enq_valid=1 and deq_ready=1 -> next cycle count=0, deq_valid=0, deq_inst=NOP_INSN; neither the pushed entry nor the popped entry takes effect.
- Drop reset low mid-stream at count=3, between clock edges -> outputs take reset values before the next edge; after release the queue behaves as empty.
